// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one riscv_alu between N_REQ requesters.
// The ALU result is captured into a 1-deep response register tagged with
// the winning requester ID. The register drains through rsp_ready and
// passes a new result through in the same cycle it drains.

// Combinational RISC-V style ALU.
// Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
// Op codes 10..15 are illegal: result 0, zero 1, illegal 1.
module riscv_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    // Decode the op code and compute the result and flags.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            4'd0:    result = a + b;
            4'd1:    result = a - b;
            4'd2:    result = a & b;
            4'd3:    result = a | b;
            4'd4:    result = a ^ b;
            4'd5:    result = {31'b0, $signed(a) < $signed(b)};
            4'd6:    result = {31'b0, a < b};
            4'd7:    result = a << b[4:0];
            4'd8:    result = a >> b[4:0];
            4'd9:    result = $unsigned($signed(a) >>> b[4:0]);
            default: illegal = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

module alu_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [4*N_REQ-1:0]    req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_illegal,
    output logic                  busy
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_next;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic            xfer;

    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [3:0]      sel_op;
    logic [31:0]     alu_result;
    logic            alu_zero;
    logic            alu_illegal;

    assign can_accept = (state == EMPTY) || (rsp_ready && (state == FULL));
    assign xfer       = rst_n && can_accept && grant_any;
    assign rsp_valid  = (state == FULL);
    assign busy       = rsp_valid;
    assign rr_next    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Round-robin search: first valid at or after rr_ptr, then wrap to the
    // indices below rr_ptr. Split into two passes so no modulo is needed.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!grant_any && (i >= 32'(rr_ptr)) && req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!grant_any && (i < 32'(rr_ptr)) && req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

    // Steer the granted requester's operands into the ALU and raise its ready.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a        = req_a[32*i +: 32];
                sel_b        = req_b[32*i +: 32];
                sel_op       = req_op[4*i +: 4];
                req_ready[i] = xfer;
            end
        end
    end

    riscv_alu u_alu (
        .a       (sel_a),
        .b       (sel_b),
        .op      (sel_op),
        .result  (alu_result),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    // Response-register occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fill on transfer, drain when consumed without a new transfer.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (xfer) state_next = FULL;
            FULL: begin
                if (xfer)           state_next = FULL;
                else if (rsp_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Capture the ALU result and advance priority only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            rsp_id      <= grant_idx;
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_illegal <= alu_illegal;
            rr_ptr      <= rr_next;
        end
    end

endmodule
